// File: rtl/rptr_empty_lvl_if.sv
// rptr_empty_lvl_if: read-side status bundle between the async-FIFO read pointer block
// and its users.
//   rinc            read request (pop when not empty)
//   rq2_wptr        Gray write pointer, already synchronized into rclk
//   rempty/raempty  registered empty / almost-empty flags
//   raddr           memory read address
//   rptr            registered Gray read pointer for the write domain
//   rlevel          fill level as seen from the read side
//   runderflow(_clr) sticky underflow flag and its clear (only with RPTR_UNDERFLOW_EN)
// Modports: master = pointer user (drives rinc/rq2_wptr), slave = rptr_empty_lvl.
interface rptr_empty_lvl_if #(
    parameter int unsigned ADDRSIZE = 4
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   rlevel;
`ifdef RPTR_UNDERFLOW_EN
    logic                runderflow;
    logic                runderflow_clr;

    modport master (
        output rinc, rq2_wptr, runderflow_clr,
        input  rempty, raempty, raddr, rptr, rlevel, runderflow
    );
    modport slave (
        input  rinc, rq2_wptr, runderflow_clr,
        output rempty, raempty, raddr, rptr, rlevel, runderflow
    );
`else
    modport master (
        output rinc, rq2_wptr,
        input  rempty, raempty, raddr, rptr, rlevel
    );
    modport slave (
        input  rinc, rq2_wptr,
        output rempty, raempty, raddr, rptr, rlevel
    );
`endif
endinterface

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read-domain pointer and status logic of a dual-clock FIFO.
// Keeps binary/Gray read pointers, drives the memory read address and produces registered
// empty, almost-empty and fill-level outputs from the synchronized Gray write pointer.
// Ports:
//   rclk    read-domain clock
//   rrst_n  asynchronous active-low reset
//   bus     rptr_empty_lvl_if.slave (rinc, rq2_wptr in; rempty, raempty, raddr, rptr,
//           rlevel out; runderflow_clr in / runderflow out when enabled)
// Optional feature: define RPTR_UNDERFLOW_EN to add the sticky underflow flag.
module rptr_empty_lvl #(
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AE_THRESH = 1
) (
    input logic             rclk,
    input logic             rrst_n,
    rptr_empty_lvl_if.slave bus
);
    localparam int unsigned PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AeThresh = PW'(AE_THRESH);

    logic [ADDRSIZE:0] r_rbin;
    logic [ADDRSIZE:0] r_rptr;
    logic              r_rempty;
    logic              r_raempty;
    logic [ADDRSIZE:0] r_rlevel;

    logic              w_pop;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;
    logic [ADDRSIZE:0] w_wbin_s;
    logic [ADDRSIZE:0] w_lvl_next;

    // Reads while empty are dropped here, so the pointers can never overtake the writer.
    assign w_pop       = bus.rinc & ~r_rempty;
    assign w_rbinnext  = r_rbin + PW'(w_pop);
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // Gray to binary: bit i is the XOR of all Gray bits from i upward.
    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_wbin_s[i] = ^(bus.rq2_wptr >> i);
        end
    end

    // Modular difference; a full FIFO shows up as 2^ADDRSIZE (MSB set, low bits equal).
    assign w_lvl_next = w_wbin_s - w_rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin    <= '0;
            r_rptr    <= '0;
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_rlevel  <= '0;
        end else begin
            r_rbin    <= w_rbinnext;
            r_rptr    <= w_rgraynext;
            // Using the next pointer lets a draining read raise empty on the same edge.
            r_rempty  <= (w_rgraynext == bus.rq2_wptr);
            r_raempty <= (w_lvl_next <= AeThresh);
            r_rlevel  <= w_lvl_next;
        end
    end

    assign bus.rempty  = r_rempty;
    assign bus.raempty = r_raempty;
    assign bus.raddr   = r_rbin[ADDRSIZE-1:0];
    assign bus.rptr    = r_rptr;
    assign bus.rlevel  = r_rlevel;

`ifdef RPTR_UNDERFLOW_EN
    logic r_runderflow;

    // Set takes priority over clear so an underflow in the clearing cycle is not lost.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_runderflow <= 1'b0;
        end else if (bus.rinc && r_rempty) begin
            r_runderflow <= 1'b1;
        end else if (bus.runderflow_clr) begin
            r_runderflow <= 1'b0;
        end
    end

    assign bus.runderflow = r_runderflow;
`endif
endmodule

// File: tb/tb_rptr_empty_lvl.sv
module tb_rptr_empty_lvl;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AE = 1;

    logic rclk;
    logic rrst_n;

    rptr_empty_lvl_if #(.ADDRSIZE(AW)) bus ();

    rptr_empty_lvl #(
        .ADDRSIZE (AW),
        .AE_THRESH(AE)
    ) dut (
        .rclk  (rclk),
        .rrst_n(rrst_n),
        .bus   (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_cmp;
    int n_fail;

    // Behavioural model: plain unbounded read/write counts.
    int m_rd;
    int m_w;
    logic m_empty;

    typedef struct {
        logic       rinc;
        int         wcnt;
        logic       e;
        logic       ae;
        int         lvl;
        int         addr;
        logic [4:0] rptr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e, input logic ae, input int lvl,
                             input int addr, input logic [4:0] rp);
        check({tag, ".rempty"}, int'(bus.rempty), int'(e));
        check({tag, ".raempty"}, int'(bus.raempty), int'(ae));
        check({tag, ".rlevel"}, int'(bus.rlevel), lvl);
        check({tag, ".raddr"}, int'(bus.raddr), addr);
        check({tag, ".rptr"}, int'(bus.rptr), int'(rp));
    endtask

    // Apply one cycle of stimulus and sample just after the edge.
    task automatic drive(input logic rinc, input int wcnt);
        @(negedge rclk);
        bus.rinc = rinc;
        bus.rq2_wptr = gray(wcnt);
        @(posedge rclk);
        #1;
    endtask

    task automatic model_step(input string tag, input logic rinc, input int wcnt);
        int lvl;
        drive(rinc, wcnt);
        if (rinc && !m_empty) m_rd++;
        m_w = wcnt;
        lvl = m_w - m_rd;
        m_empty = (lvl == 0);
        check_all(tag, m_empty, lvl <= AE, lvl, m_rd % DEPTH, gray(m_rd));
    endtask

    task automatic do_reset();
        @(negedge rclk);
        bus.rinc = 1'b0;
        bus.rq2_wptr = '0;
`ifdef RPTR_UNDERFLOW_EN
        bus.runderflow_clr = 1'b0;
`endif
        rrst_n = 1'b0;
        #12;
        @(negedge rclk);
        rrst_n = 1'b1;
        m_rd = 0;
        m_w = 0;
        m_empty = 1'b1;
    endtask

    initial begin
        logic [4:0] prev;
        int         wnew;
        n_cmp = 0;
        n_fail = 0;
        rrst_n = 1'b1;
        bus.rinc = 1'b0;
        bus.rq2_wptr = '0;
`ifdef RPTR_UNDERFLOW_EN
        bus.runderflow_clr = 1'b0;
`endif
        do_reset();
        check_all("reset", 1'b1, 1'b1, 0, 0, 5'b00000);

        // Fill 3, drain 3, underflow attempt, then jump to full and read one.
        vecs.push_back('{1'b0, 3,  1'b0, 1'b0, 3,  0, 5'b00000});
        vecs.push_back('{1'b1, 3,  1'b0, 1'b0, 2,  1, 5'b00001});
        vecs.push_back('{1'b1, 3,  1'b0, 1'b1, 1,  2, 5'b00011});
        vecs.push_back('{1'b1, 3,  1'b1, 1'b1, 0,  3, 5'b00010});
        vecs.push_back('{1'b1, 3,  1'b1, 1'b1, 0,  3, 5'b00010});
        vecs.push_back('{1'b0, 19, 1'b0, 1'b0, 16, 3, 5'b00010});
        vecs.push_back('{1'b1, 19, 1'b0, 1'b0, 15, 4, 5'b00110});
        vecs.push_back('{1'b1, 20, 1'b0, 1'b0, 15, 5, 5'b00111});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rinc, vecs[i].wcnt);
            check_all($sformatf("vec%0d", i), vecs[i].e, vecs[i].ae, vecs[i].lvl,
                      vecs[i].addr, vecs[i].rptr);
        end

        // Underflow: stays parked at empty, sticky flag when enabled.
        do_reset();
        model_step("uf", 1'b1, 0);
`ifdef RPTR_UNDERFLOW_EN
        check("uf.set", int'(bus.runderflow), 1);
        model_step("uf_hold", 1'b0, 0);
        check("uf.hold", int'(bus.runderflow), 1);
        @(negedge rclk);
        bus.runderflow_clr = 1'b1;
        bus.rinc = 1'b1;
        @(posedge rclk);
        #1;
        check("uf.setwins", int'(bus.runderflow), 1);
        @(negedge rclk);
        bus.rinc = 1'b0;
        @(posedge rclk);
        #1;
        check("uf.clr", int'(bus.runderflow), 0);
        @(negedge rclk);
        bus.runderflow_clr = 1'b0;
`endif

        // Wrap: park the read pointer at 30, then read across the top.
        do_reset();
        model_step("w16", 1'b0, 16);
        for (int i = 0; i < 16; i++) model_step("wr_a", 1'b1, 16);
        model_step("w30", 1'b0, 30);
        for (int i = 0; i < 14; i++) model_step("wr_b", 1'b1, 30);
        check("wrap.rptr30", int'(bus.rptr), 5'b10001);
        model_step("w33", 1'b0, 33);
        prev = bus.rptr;
        for (int i = 0; i < 3; i++) begin
            model_step("wrap", 1'b1, 33);
            check("wrap.onebit", $countones(prev ^ bus.rptr), 1);
            prev = bus.rptr;
        end
        check("wrap.rempty", int'(bus.rempty), 1);

        // Asynchronous reset mid-stream with rptr = Gray(7).
        do_reset();
        model_step("pre", 1'b0, 10);
        for (int i = 0; i < 7; i++) model_step("pre_rd", 1'b1, 10);
        check("pre.rptr7", int'(bus.rptr), 5'b00100);
        #2;
        rrst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b1, 1'b1, 0, 0, 5'b00000);
        do_reset();

        // Random traffic: writer jumps by 0..3, capped so occupancy stays legal.
        for (int i = 0; i < 400; i++) begin
            wnew = m_w + int'($urandom_range(0, 3));
            if (wnew - m_rd > DEPTH) wnew = m_rd + DEPTH;
            model_step("rand", 1'($urandom_range(0, 1)), wnew);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
